// File: rtl/alu_sequencer.sv
// Issue/writeback controller for a combinational ALU: a 4-entry register file,
// an instruction handshake, and a response handshake that carries the result and flags.
module alu_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       instr_op,
    input  logic [1:0]       instr_rd,
    input  logic [1:0]       instr_rs,
    input  logic [1:0]       instr_rt,
    input  logic [WIDTH-1:0] instr_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_carry,
    input  logic [1:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int unsigned NREG = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rf [NREG];
    logic [1:0]       rd_q;
    logic             loadi_q;
    logic [WIDTH-1:0] imm_q;

    assign dbg_data = rf[dbg_sel];

    // Operands are read at acceptance; LOADI leaves the ALU inputs untouched
    // since its result never depends on the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            rsp_valid   <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            rsp_data    <= '0;
            rsp_zero    <= 1'b0;
            rsp_carry   <= 1'b0;
            rd_q        <= '0;
            loadi_q     <= 1'b0;
            imm_q       <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        rd_q        <= instr_rd;
                        loadi_q     <= instr_op[3];
                        imm_q       <= instr_imm;
                        if (!instr_op[3]) begin
                            alu_a  <= rf[instr_rs];
                            alu_b  <= rf[instr_rt];
                            alu_op <= instr_op[2:0];
                        end
                        instr_ready <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (loadi_q) begin
                        rf[rd_q]  <= imm_q;
                        rsp_data  <= imm_q;
                        rsp_zero  <= (imm_q == '0);
                        rsp_carry <= 1'b0;
                    end else begin
                        rf[rd_q]  <= alu_result;
                        rsp_data  <= alu_result;
                        rsp_zero  <= alu_zero;
                        rsp_carry <= alu_carry;
                    end
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        instr_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid   <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: the bench plays the ALU, keeps an architectural
// register-file model, and checks outputs every cycle plus hand-computed literals.
module tb_alu_sequencer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [3:0]   instr_op = '0;
    logic [1:0]   instr_rd = '0;
    logic [1:0]   instr_rs = '0;
    logic [1:0]   instr_rt = '0;
    logic [W-1:0] instr_imm = '0;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_result;
    logic         alu_zero;
    logic         alu_carry;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_zero;
    logic         rsp_carry;
    logic [1:0]   dbg_sel = '0;
    logic [W-1:0] dbg_data;

    int checks = 0;
    int errors = 0;

    // Architectural model state
    logic [W-1:0] mrf [4];
    logic         pending = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic         exp_zero = 1'b0;
    logic         exp_carry = 1'b0;
    logic [W-1:0] prev_a = '0;
    logic [W-1:0] prev_b = '0;
    logic [2:0]   prev_op = '0;

    // Values observed from the DUT by the last issue, for literal checks
    logic [W-1:0] got_data;
    logic         got_zero;
    logic         got_carry;
    logic [W-1:0] got_a;
    logic [W-1:0] got_b;
    logic [2:0]   got_op;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_SHL = 3'd6;
    localparam logic [3:0] LOADI = 4'b1000;

    alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
        .instr_rt(instr_rt), .instr_imm(instr_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {zero, carry, result}; SUB carry is the borrow
    function automatic logic [W+1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        s = '0;
        c = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = s[W]; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = a << 1; c = a[W-1]; end
            default: begin r = a >> 1; c = a[0]; end
        endcase
        return {(r == '0), c, r};
    endfunction

    always_comb begin
        {alu_zero, alu_carry, alu_result} = alu_f(alu_op, alu_a, alu_b);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_valid_exclusive", 32'(instr_ready & rsp_valid), 32'd0);
            if (rsp_valid) begin
                chk("rsp_data", 32'(rsp_data), 32'(exp_data));
                chk("rsp_zero", 32'(rsp_zero), 32'(exp_zero));
                chk("rsp_carry", 32'(rsp_carry), 32'(exp_carry));
            end
            if (!pending) chk("dbg_data", 32'(dbg_data), 32'(mrf[dbg_sel]));
        end
    end

    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt, input logic [W-1:0] imm, input int stall,
                         input bit hold_valid);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W+1:0] f;
        int n;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
        dbg_sel = rd;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(instr_ready), 32'd1);
        a = mrf[rs];
        b = mrf[rt];
        f = op[3] ? {(imm == '0), 1'b0, imm} : alu_f(op[2:0], a, b);
        {exp_zero, exp_carry, exp_data} = f;
        @(posedge clk);
        pending = 1'b1;
        @(negedge clk);
        if (!hold_valid) instr_valid = 1'b0;
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("exec_instr_ready", 32'(instr_ready), 32'd0);
        if (!op[3]) begin
            prev_a = a; prev_b = b; prev_op = op[2:0];
        end
        chk("exec_alu_a", 32'(alu_a), 32'(prev_a));
        chk("exec_alu_b", 32'(alu_b), 32'(prev_b));
        chk("exec_alu_op", 32'(alu_op), 32'(prev_op));
        got_a = alu_a; got_b = alu_b; got_op = alu_op;
        rsp_ready = (stall == 0);
        @(negedge clk);
        chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
        got_data = rsp_data; got_zero = rsp_zero; got_carry = rsp_carry;
        for (int i = 0; i < stall; i++) begin
            chk("stall_instr_ready", 32'(instr_ready), 32'd0);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        mrf[rd] = f[W-1:0];
        pending = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_instr_ready", 32'(instr_ready), 32'd1);
        instr_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) mrf[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        rst_n = 1'b1;

        issue(LOADI, 2'd1, 2'd0, 2'd0, 4'd9, 0, 1'b0);
        chk("loadi9_data", 32'(got_data), 32'd9);
        chk("loadi9_flags", 32'({got_zero, got_carry}), 32'd0);
        issue(LOADI, 2'd2, 2'd0, 2'd0, 4'd8, 0, 1'b0);
        chk("loadi8_data", 32'(got_data), 32'd8);
        @(negedge clk);
        dbg_sel = 2'd1;
        @(negedge clk);
        chk("dbg_r1", 32'(dbg_data), 32'd9);

        issue({1'b0, OP_ADD}, 2'd3, 2'd1, 2'd2, '0, 0, 1'b0);
        chk("add_alu_a", 32'(got_a), 32'd9);
        chk("add_alu_b", 32'(got_b), 32'd8);
        chk("add_alu_op", 32'(got_op), 32'd0);
        chk("add_data", 32'(got_data), 32'd1);
        chk("add_zc", 32'({got_zero, got_carry}), 32'b01);

        issue({1'b0, OP_SUB}, 2'd0, 2'd1, 2'd1, '0, 0, 1'b0);
        chk("sub_self_data", 32'(got_data), 32'd0);
        chk("sub_self_zc", 32'({got_zero, got_carry}), 32'b10);
        issue({1'b0, OP_SUB}, 2'd0, 2'd2, 2'd1, '0, 0, 1'b0);
        chk("sub_borrow_data", 32'(got_data), 32'd15);
        chk("sub_borrow_c", 32'(got_carry), 32'd1);

        issue({1'b0, OP_SHL}, 2'd1, 2'd1, 2'd1, '0, 0, 1'b0);
        chk("shl1_data", 32'(got_data), 32'd2);
        chk("shl1_c", 32'(got_carry), 32'd1);
        issue({1'b0, OP_SHL}, 2'd1, 2'd1, 2'd1, '0, 0, 1'b0);
        chk("shl2_alu_a", 32'(got_a), 32'd2);
        chk("shl2_data", 32'(got_data), 32'd4);
        chk("shl2_c", 32'(got_carry), 32'd0);

        // r3 = r1 - r2 = 4 - 8 under backpressure with valid held high
        issue({1'b0, OP_SUB}, 2'd3, 2'd1, 2'd2, '0, 5, 1'b1);
        chk("bp_data", 32'(got_data), 32'd12);
        chk("bp_c", 32'(got_carry), 32'd1);

        issue(LOADI, 2'd2, 2'd0, 2'd0, 4'd0, 0, 1'b0);
        chk("loadi0_zc", 32'({got_zero, got_carry}), 32'b10);
        chk("loadi0_alu_op", 32'(got_op), 32'(OP_SUB));

        // Reset during EXEC of ADD r3 = r1 + r2
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op = {1'b0, OP_ADD}; instr_rd = 2'd3; instr_rs = 2'd1; instr_rt = 2'd2;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        instr_valid = 1'b0;
        for (int i = 0; i < 4; i++) mrf[i] = '0;
        pending = 1'b0;
        prev_a = '0; prev_b = '0; prev_op = '0;
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
        chk("mid_rst_rsp", 32'({rsp_valid, rsp_data, rsp_zero, rsp_carry}), 32'd0);
        chk("mid_rst_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        dbg_sel = 2'd3;
        @(negedge clk);
        chk("mid_rst_r3", 32'(dbg_data), 32'd0);

        issue(LOADI, 2'd1, 2'd0, 2'd0, 4'd5, 0, 1'b0);
        issue({1'b0, OP_ADD}, 2'd3, 2'd1, 2'd1, '0, 0, 1'b0);
        chk("post_rst_add", 32'(got_data), 32'd10);
        chk("post_rst_zc", 32'({got_zero, got_carry}), 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
